stc_b_dn_sched: RTL and testbench
=================================

STC_B_DN_SCHED -- requirements
Module: stc_b_dn_sched

Interface
REQ-001 SHALL have parameter K, default 16, max nonzeros per A-row (crossbar input lines).
REQ-002 SHALL have parameter N_PE, default 4, crossbar output lanes per issue beat; K SHALL be a multiple of N_PE.
REQ-003 SHALL have parameter DW_COL, default 4, column-index width (log2 K).
REQ-004 SHALL have parameter DW_CNT, default 5, nonzero-count width (log2 K + 1).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 row_valid  input  1  row metadata available.
REQ-008 row_ready  output  1  row metadata accepted when row_valid & row_ready.
REQ-009 row_cols  input  K*DW_COL  packed nonzero column indices, entry j at bits [j*DW_COL +: DW_COL].
REQ-010 row_nnz  input  DW_CNT  number of valid entries in row_cols.
REQ-011 row_last  input  1  row is last of current tile.
REQ-012 iss_valid  output  1  issue beat presented to crossbar idx port.
REQ-013 iss_ready  input  1  downstream accepts beat when iss_valid & iss_ready.
REQ-014 iss_cols  output  N_PE*DW_COL  per-lane column select.
REQ-015 iss_mask  output  N_PE  per-lane valid bit.
REQ-016 iss_row_end  output  1  beat is final beat of its row.
REQ-017 iss_tile_end  output  1  beat is final beat of a row_last row.
REQ-018 busy  output  1  high in ISSUE state.

Function
REQ-019 FSM states: IDLE, ISSUE; row_ready = (state==IDLE) | (iss_valid & iss_ready & iss_row_end).
REQ-020 On row accept: latch row_cols, row_last; nnz_eff = min(row_nnz, K); ptr <= 0; state <= ISSUE next cycle (one-cycle accept-to-issue latency).
REQ-021 Beats per row = max(1, ceil(nnz_eff/N_PE)); nnz_eff==0 yields one beat with iss_mask all zero.
REQ-022 Beat lane i: iss_mask[i] = (ptr+i < nnz_eff); iss_cols lane i = latched entry ptr+i when masked-in, else 0.
REQ-023 iss_row_end = (ptr + N_PE >= nnz_eff); iss_tile_end = iss_row_end & latched row_last.
REQ-024 iss_valid, iss_cols, iss_mask, iss_row_end, iss_tile_end SHALL be held stable while iss_valid & ~iss_ready.
REQ-025 On accepted non-final beat: ptr <= ptr + N_PE.
REQ-026 On accepted final beat with row_valid high: new row accepted same cycle, ISSUE continues with new row, no bubble.
REQ-027 On accepted final beat with row_valid low: state <= IDLE, iss_valid deasserts next cycle.
REQ-028 Outputs SHALL be registered; no combinational path row_* -> iss_*.

Reset
REQ-029 Reset low: state IDLE, ptr 0, iss_valid 0, iss_cols 0, iss_mask 0, iss_row_end 0, iss_tile_end 0, busy 0, row_ready 1 after release.
REQ-030 Reset mid-row SHALL discard the in-flight row; no beat of it issues after release.

Configuration
REQ-031 With STC_B_DN_SCHED_PERF_EN defined: outputs perf_beats (32b, accepted beats) and perf_stall (32b, cycles iss_valid & ~iss_ready), wrap-around, cleared by reset.
REQ-032 Without STC_B_DN_SCHED_PERF_EN: those ports and counters absent; all other behaviour identical.

Verification
REQ-033 nnz=6, cols 3,7,1,9,0,15, iss_ready=1 -> beat1 cols{3,7,1,9} mask 1111; beat2 cols{0,15,0,0} mask 0011 row_end=1.
REQ-034 nnz=0, row_last=1 -> single beat mask 0000, row_end=1, tile_end=1.
REQ-035 Two back-to-back rows nnz=4 each, row_valid held -> beats on consecutive cycles, row_ready pulses with each final beat.
REQ-036 nnz=8, iss_ready low 3 cycles on beat1 -> outputs stable, perf_stall=3 (PERF_EN), then beat2.
REQ-037 row_nnz=20 (>K) -> treated as 16, four full beats, mask 1111 each.
REQ-038 reset asserted during beat2 of nnz=12 row -> outputs zero immediately, row_ready=1 after release, no residual beats.

Source files
------------

// File: rtl/stc_b_dn_sched.sv
// rtl/stc_b_dn_sched.sv - sparse-row to crossbar issue-beat scheduler
// Optional perf_beats/perf_stall counters under STC_B_DN_SCHED_PERF_EN.
module stc_b_dn_sched #(
    parameter int K      = 16,
    parameter int N_PE   = 4,
    parameter int DW_COL = 4,
    parameter int DW_CNT = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     row_valid,
    output logic                     row_ready,
    input  logic [K*DW_COL-1:0]      row_cols,
    input  logic [DW_CNT-1:0]        row_nnz,
    input  logic                     row_last,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output logic [N_PE*DW_COL-1:0]   iss_cols,
    output logic [N_PE-1:0]          iss_mask,
    output logic                     iss_row_end,
    output logic                     iss_tile_end,
`ifdef STC_B_DN_SCHED_PERF_EN
    output logic [31:0]              perf_beats,
    output logic [31:0]              perf_stall,
`endif
    output logic                     busy
);

    localparam int PW = DW_CNT + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                   state, state_nx;
    logic [K*DW_COL-1:0]      cols_q;
    logic [DW_CNT-1:0]        nnz_q;
    logic [DW_CNT-1:0]        ptr_q;
    logic                     last_q;

    logic                     beat_acc, row_acc, load, clear;
    logic [K*DW_COL-1:0]      src_cols;
    logic [DW_CNT-1:0]        src_nnz;
    logic [DW_CNT-1:0]        src_ptr;
    logic                     src_last;
    logic [PW-1:0]            pos;
    logic [N_PE*DW_COL-1:0]   nx_cols;
    logic [N_PE-1:0]          nx_mask;
    logic                     nx_row_end;

    assign beat_acc  = iss_valid & iss_ready;
    assign row_ready = (state == IDLE) | (beat_acc & iss_row_end);
    assign row_acc   = row_valid & row_ready;
    assign busy      = (state == ISSUE);

    // A new row is loaded straight into the output registers, so the first
    // beat appears the cycle after acceptance with no path from row_* to iss_*.
    assign load  = row_acc | (beat_acc & ~iss_row_end);
    assign clear = beat_acc & iss_row_end & ~row_valid;

    always_comb begin
        src_cols   = cols_q;
        src_nnz    = nnz_q;
        src_ptr    = ptr_q + DW_CNT'(N_PE);
        src_last   = last_q;
        pos        = '0;
        nx_cols    = '0;
        nx_mask    = '0;
        if (row_acc) begin
            src_cols = row_cols;
            src_nnz  = (row_nnz > DW_CNT'(K)) ? DW_CNT'(K) : row_nnz;
            src_ptr  = '0;
            src_last = row_last;
        end
        for (int i = 0; i < N_PE; i++) begin
            pos = PW'(src_ptr) + PW'(i);
            if (pos < PW'(src_nnz)) begin
                nx_mask[i] = 1'b1;
                nx_cols[i*DW_COL +: DW_COL] = src_cols[pos[DW_COL-1:0]*DW_COL +: DW_COL];
            end
        end
        nx_row_end = (PW'(src_ptr) + PW'(N_PE)) >= PW'(src_nnz);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (row_acc) state_nx = ISSUE;
            ISSUE:   if (clear)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cols_q       <= '0;
            nnz_q        <= '0;
            ptr_q        <= '0;
            last_q       <= 1'b0;
            iss_valid    <= 1'b0;
            iss_cols     <= '0;
            iss_mask     <= '0;
            iss_row_end  <= 1'b0;
            iss_tile_end <= 1'b0;
        end else if (load) begin
            cols_q       <= src_cols;
            nnz_q        <= src_nnz;
            ptr_q        <= src_ptr;
            last_q       <= src_last;
            iss_valid    <= 1'b1;
            iss_cols     <= nx_cols;
            iss_mask     <= nx_mask;
            iss_row_end  <= nx_row_end;
            iss_tile_end <= nx_row_end & src_last;
        end else if (clear) begin
            ptr_q        <= '0;
            iss_valid    <= 1'b0;
            iss_cols     <= '0;
            iss_mask     <= '0;
            iss_row_end  <= 1'b0;
            iss_tile_end <= 1'b0;
        end
    end

`ifdef STC_B_DN_SCHED_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_beats <= '0;
            perf_stall <= '0;
        end else begin
            if (beat_acc)               perf_beats <= perf_beats + 32'd1;
            if (iss_valid & ~iss_ready) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stc_b_dn_sched.sv
// tb/tb_stc_b_dn_sched.sv - self-checking bench for stc_b_dn_sched
module tb_stc_b_dn_sched;

    localparam int K      = 16;
    localparam int N_PE   = 4;
    localparam int DW_COL = 4;
    localparam int DW_CNT = 5;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    row_valid;
    logic                    row_ready;
    logic [K*DW_COL-1:0]     row_cols;
    logic [DW_CNT-1:0]       row_nnz;
    logic                    row_last;
    logic                    iss_valid;
    logic                    iss_ready;
    logic [N_PE*DW_COL-1:0]  iss_cols;
    logic [N_PE-1:0]         iss_mask;
    logic                    iss_row_end;
    logic                    iss_tile_end;
    logic                    busy;
`ifdef STC_B_DN_SCHED_PERF_EN
    logic [31:0]             perf_beats;
    logic [31:0]             perf_stall;
`endif

    stc_b_dn_sched #(.K(K), .N_PE(N_PE), .DW_COL(DW_COL), .DW_CNT(DW_CNT)) dut (
        .clk(clk), .reset(reset),
        .row_valid(row_valid), .row_ready(row_ready), .row_cols(row_cols),
        .row_nnz(row_nnz), .row_last(row_last),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_cols(iss_cols),
        .iss_mask(iss_mask), .iss_row_end(iss_row_end), .iss_tile_end(iss_tile_end),
`ifdef STC_B_DN_SCHED_PERF_EN
        .perf_beats(perf_beats), .perf_stall(perf_stall),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_PE*DW_COL-1:0] cols;
        logic [N_PE-1:0]        mask;
        bit                     re;
        bit                     te;
    } beat_t;

    beat_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: split the row into fixed groups of N_PE entries by index.
    task automatic push_row(input logic [K*DW_COL-1:0] c, input int nnz, input bit last);
        int eff, nb, idx;
        beat_t b;
        eff = (nnz > K) ? K : nnz;
        nb  = (eff == 0) ? 1 : (eff + N_PE - 1) / N_PE;
        for (int bi = 0; bi < nb; bi++) begin
            b.cols = '0;
            b.mask = '0;
            for (int l = 0; l < N_PE; l++) begin
                idx = bi * N_PE + l;
                if (idx < eff) begin
                    b.mask[l] = 1'b1;
                    b.cols[l*DW_COL +: DW_COL] = c[idx*DW_COL +: DW_COL];
                end
            end
            b.re = (bi == nb - 1);
            b.te = b.re && last;
            exp_q.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            chk("rst_iss_valid", 64'(iss_valid), 64'd0);
            chk("rst_iss_cols", 64'(iss_cols), 64'd0);
        end else begin
            chk("mdl_iss_valid", 64'(iss_valid), 64'(exp_q.size() != 0));
            chk("mdl_busy", 64'(busy), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("mdl_iss_cols", 64'(iss_cols), 64'(exp_q[0].cols));
                chk("mdl_iss_mask", 64'(iss_mask), 64'(exp_q[0].mask));
                chk("mdl_row_end", 64'(iss_row_end), 64'(exp_q[0].re));
                chk("mdl_tile_end", 64'(iss_tile_end), 64'(exp_q[0].te));
                chk("mdl_row_ready", 64'(row_ready), 64'(iss_ready && exp_q[0].re));
            end else begin
                chk("mdl_row_ready", 64'(row_ready), 64'd1);
            end
            if (iss_valid && iss_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (row_valid && row_ready) push_row(row_cols, int'(row_nnz), row_last);
        end
    end

    task automatic send_row(input logic [K*DW_COL-1:0] c, input int nnz, input bit last);
        int t;
        @(posedge clk); #1;
        row_valid = 1'b1;
        row_cols  = c;
        row_nnz   = DW_CNT'(nnz);
        row_last  = last;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!row_ready && t < 100);
        if (!row_ready) chk("row_accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        row_valid = 1'b0;
    endtask

    task automatic drain();
        iss_ready = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        reset     = 1'b0;
        row_valid = 1'b0;
        row_cols  = '0;
        row_nnz   = '0;
        row_last  = 1'b0;
        iss_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_iss_mask", 64'(iss_mask), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("reset_row_ready", 64'(row_ready), 64'd1);

        // six nonzeros: two beats, second one partially masked
        send_row(64'h0000_0000_00F0_9173, 6, 1'b0);
        @(negedge clk);
        chk("r6_b1_cols", 64'(iss_cols), 64'h9173);
        chk("r6_b1_mask", 64'(iss_mask), 64'hF);
        chk("r6_b1_end", 64'(iss_row_end), 64'd0);
        @(negedge clk);
        chk("r6_b2_cols", 64'(iss_cols), 64'h00F0);
        chk("r6_b2_mask", 64'(iss_mask), 64'h3);
        chk("r6_b2_end", 64'(iss_row_end), 64'd1);
        @(negedge clk);
        chk("r6_idle", 64'(iss_valid), 64'd0);
        drain();

        // empty last row
        send_row(64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1);
        @(negedge clk);
        chk("r0_valid", 64'(iss_valid), 64'd1);
        chk("r0_mask", 64'(iss_mask), 64'h0);
        chk("r0_cols", 64'(iss_cols), 64'h0);
        chk("r0_row_end", 64'(iss_row_end), 64'd1);
        chk("r0_tile_end", 64'(iss_tile_end), 64'd1);
        drain();

        // back-to-back rows with row_valid held
        @(posedge clk); #1;
        row_valid = 1'b1; row_cols = 64'h4321; row_nnz = 5'd4; row_last = 1'b0;
        @(negedge clk);
        chk("b2b_accept_a", 64'(row_ready), 64'd1);
        @(posedge clk); #1;
        row_cols = 64'h8765; row_last = 1'b1;
        @(negedge clk);
        chk("b2b_a_cols", 64'(iss_cols), 64'h4321);
        chk("b2b_a_ready", 64'(row_ready), 64'd1);
        @(posedge clk); #1;
        row_valid = 1'b0;
        @(negedge clk);
        chk("b2b_b_valid", 64'(iss_valid), 64'd1);
        chk("b2b_b_cols", 64'(iss_cols), 64'h8765);
        chk("b2b_b_tile", 64'(iss_tile_end), 64'd1);
        drain();

        // stall on beat 1 for three cycles
        do_reset();
        iss_ready = 1'b0;
        send_row(64'h7654_3210, 8, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("stall_b1_cols", 64'(iss_cols), 64'h3210);
            chk("stall_b1_valid", 64'(iss_valid), 64'd1);
            @(posedge clk); #1;
        end
        iss_ready = 1'b1;
        @(negedge clk);
        chk("stall_b1_hold", 64'(iss_cols), 64'h3210);
`ifdef STC_B_DN_SCHED_PERF_EN
        chk("perf_stall", 64'(perf_stall), 64'd3);
`endif
        @(negedge clk);
        chk("stall_b2_cols", 64'(iss_cols), 64'h7654);
        chk("stall_b2_end", 64'(iss_row_end), 64'd1);
        drain();

        // nnz beyond K is clamped
        send_row(64'hFEDC_BA98_7654_3210, 20, 1'b0);
        for (int b = 0; b < 4; b++) begin
            logic [63:0] all_cols;
            all_cols = 64'hFEDC_BA98_7654_3210;
            @(negedge clk);
            chk("clamp_cols", 64'(iss_cols), 64'(all_cols[b*16 +: 16]));
            chk("clamp_mask", 64'(iss_mask), 64'hF);
            chk("clamp_end", 64'(iss_row_end), 64'(b == 3));
        end
        @(negedge clk);
        chk("clamp_idle", 64'(iss_valid), 64'd0);
        drain();

        // reset during beat 2 of a 12-entry row
        send_row(64'hBA98_7654_3210, 12, 1'b1);
        @(negedge clk);
        chk("rmid_b1", 64'(iss_cols), 64'h3210);
        @(posedge clk); #1;
        chk("rmid_b2", 64'(iss_cols), 64'h7654);
        reset = 1'b0;
        #1;
        chk("rmid_valid0", 64'(iss_valid), 64'd0);
        chk("rmid_cols0", 64'(iss_cols), 64'd0);
        chk("rmid_end0", 64'(iss_row_end), 64'd0);
        chk("rmid_busy0", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rmid_row_ready", 64'(row_ready), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("rmid_no_residual", 64'(iss_valid), 64'd0);
        end

        // randomized traffic, checked by the model process
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            acc = row_valid & row_ready;
            @(posedge clk); #1;
            if (acc || !row_valid) begin
                row_valid = ($urandom_range(0, 2) != 0);
                for (int j = 0; j < K; j++) row_cols[j*DW_COL +: DW_COL] = DW_COL'($urandom);
                row_nnz  = ($urandom_range(0, 7) == 0) ? DW_CNT'($urandom_range(17, 31))
                                                       : DW_CNT'($urandom_range(0, 16));
                row_last = $urandom_range(0, 1) == 1;
            end
            iss_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        row_valid = 1'b0;
        drain();
        chk("final_idle", 64'(iss_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
